// File: rtl/life_stepper_pkg.sv
// Shared board geometry, word/position types and the stepper state encoding
// for the Game of Life generation engine.
package life_stepper_pkg;

    localparam int BOARD_SIZE        = 32;
    localparam int LOG_BOARD_SIZE    = 5;
    localparam int WORD_SIZE         = 16;
    localparam int LOG_WORD_SIZE     = 4;
    localparam int WORDS_PER_ROW     = BOARD_SIZE / WORD_SIZE;
    localparam int LOG_WORDS_PER_ROW = LOG_BOARD_SIZE - LOG_WORD_SIZE;
    localparam int LOG_MAX_ADDR      = LOG_BOARD_SIZE + LOG_WORDS_PER_ROW;
    localparam int NUM_WORDS         = BOARD_SIZE * WORDS_PER_ROW;

    typedef logic [LOG_BOARD_SIZE-1:0]    pos_t;
    typedef logic [LOG_WORDS_PER_ROW-1:0] word_idx_t;
    typedef logic [WORD_SIZE-1:0]         word_t;
    typedef logic [LOG_MAX_ADDR-1:0]      addr_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EVAL  = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } stepper_state_t;

    // Both dimensions are powers of two, so row-major addressing is a concatenation.
    function automatic addr_t word_addr(input pos_t row, input word_idx_t w);
        return {row, w};
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int b = 0; b < 8; b++) begin
            c = c + {3'b000, v[b]};
        end
        return c;
    endfunction

endpackage

// File: rtl/life_stepper_eval.sv
// Combinational next-generation evaluation of one centre word from its
// 3x3 word neighbourhood (B3/S23), with cross-word edge neighbours.
module life_word_eval
    import life_stepper_pkg::*;
(
    input  word_t [2:0][2:0] nbr_i,
    output word_t            next_o
);

    // Each row extended by one cell on each side: {left word LSB, centre, right word MSB}.
    logic [WORD_SIZE+1:0] ext [3];

    for (genvar r = 0; r < 3; r++) begin : g_row
        assign ext[r] = {nbr_i[r][0][0], nbr_i[r][1], nbr_i[r][2][WORD_SIZE-1]};
    end

    for (genvar i = 0; i < WORD_SIZE; i++) begin : g_bit
        logic [3:0] cnt;
        logic       alive;

        assign alive  = ext[1][i+1];
        assign cnt    = popcount8({ext[0][i+2], ext[0][i+1], ext[0][i],
                                   ext[1][i+2],              ext[1][i],
                                   ext[2][i+2], ext[2][i+1], ext[2][i]});
        assign next_o[i] = (cnt == 4'd3) | (alive & (cnt == 4'd2));
    end

endmodule

// File: rtl/life_stepper.sv
// Walks the board word by word: fetches 9 neighbour words, evaluates one
// result word and writes it to the destination buffer, then pulses done.
module life_stepper
    import life_stepper_pkg::*;
#(
    parameter int READ_LATENCY = 2,
    parameter int GEN_WIDTH    = 16
) (
    input  logic                 clk_130mhz,
    input  logic                 rst_in,
    input  logic                 start_in,
    input  logic [WORD_SIZE-1:0] data_r_in,
    output logic [LOG_MAX_ADDR-1:0] addr_r_out,
    output logic [LOG_MAX_ADDR-1:0] addr_w_out,
    output logic [WORD_SIZE-1:0] data_w_out,
    output logic                 we_out,
    output logic                 busy_out,
    output logic                 done_out,
    output logic [GEN_WIDTH-1:0] gen_count_out,
    output stepper_state_t       state_out
);

    localparam int WAIT_W = $clog2(READ_LATENCY + 1);

    stepper_state_t state_q, state_d;

    pos_t                 row_q, row_d;
    word_idx_t            w_q, w_d;
    logic [1:0]           frow_q, frow_d;
    logic [1:0]           fcol_q, fcol_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    word_t                result_q, result_d;
    logic [GEN_WIDTH-1:0] gen_q, gen_d;

    // Read-return tracking: a valid bit and neighbour slot per outstanding read.
    logic [READ_LATENCY-1:0] vld_q;
    logic [3:0]              tag_q [READ_LATENCY];
    word_t [2:0][2:0]        nbr_q;

    word_t     eval_word;
    pos_t      fetch_row;
    word_idx_t fetch_w;
    logic      fetching;
    logic      last_word;

    life_word_eval u_eval (
        .nbr_i  (nbr_q),
        .next_o (eval_word)
    );

    assign fetching  = (state_q == ST_FETCH);
    assign last_word = (row_q == pos_t'(BOARD_SIZE - 1)) &&
                       (w_q == word_idx_t'(WORDS_PER_ROW - 1));

    // Offsets of -1/0/+1 wrap naturally because both dimensions are powers of two.
    assign fetch_row = row_q + pos_t'(frow_q) - pos_t'(1);
    assign fetch_w   = w_q + word_idx_t'(fcol_q) - word_idx_t'(1);

    always_ff @(posedge clk_130mhz) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        w_d      = w_q;
        frow_d   = frow_q;
        fcol_d   = fcol_q;
        wait_d   = wait_q;
        result_d = result_q;
        gen_d    = gen_q;

        case (state_q)
            ST_IDLE: begin
                if (start_in) begin
                    row_d   = '0;
                    w_d     = '0;
                    frow_d  = '0;
                    fcol_d  = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (fcol_q == 2'd2) begin
                    fcol_d = '0;
                    if (frow_q == 2'd2) begin
                        frow_d  = '0;
                        wait_d  = '0;
                        state_d = ST_WAIT;
                    end else begin
                        frow_d = frow_q + 2'd1;
                    end
                end else begin
                    fcol_d = fcol_q + 2'd1;
                end
            end
            ST_WAIT: begin
                if (wait_q == WAIT_W'(READ_LATENCY - 1)) begin
                    state_d = ST_EVAL;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_EVAL: begin
                result_d = eval_word;
                state_d  = ST_WRITE;
            end
            ST_WRITE: begin
                if (last_word) begin
                    gen_d   = gen_q + GEN_WIDTH'(1);
                    state_d = ST_DONE;
                end else begin
                    w_d = w_q + word_idx_t'(1);
                    if (w_q == word_idx_t'(WORDS_PER_ROW - 1)) begin
                        row_d = row_q + pos_t'(1);
                    end
                    state_d = ST_FETCH;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_130mhz) begin
        if (rst_in) begin
            row_q    <= '0;
            w_q      <= '0;
            frow_q   <= '0;
            fcol_q   <= '0;
            wait_q   <= '0;
            result_q <= '0;
            gen_q    <= '0;
            vld_q    <= '0;
            nbr_q    <= '0;
            for (int s = 0; s < READ_LATENCY; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            row_q    <= row_d;
            w_q      <= w_d;
            frow_q   <= frow_d;
            fcol_q   <= fcol_d;
            wait_q   <= wait_d;
            result_q <= result_d;
            gen_q    <= gen_d;
            vld_q[0] <= fetching;
            tag_q[0] <= {frow_q, fcol_q};
            for (int s = 1; s < READ_LATENCY; s++) begin
                vld_q[s] <= vld_q[s-1];
                tag_q[s] <= tag_q[s-1];
            end
            if (vld_q[READ_LATENCY-1]) begin
                nbr_q[tag_q[READ_LATENCY-1][3:2]][tag_q[READ_LATENCY-1][1:0]] <= data_r_in;
            end
        end
    end

    assign addr_r_out    = fetching ? word_addr(fetch_row, fetch_w) : '0;
    assign we_out        = (state_q == ST_WRITE);
    assign addr_w_out    = we_out ? word_addr(row_q, w_q) : '0;
    assign data_w_out    = we_out ? result_q : '0;
    assign busy_out      = (state_q == ST_FETCH) || (state_q == ST_WAIT) ||
                           (state_q == ST_EVAL)  || (state_q == ST_WRITE);
    assign done_out      = (state_q == ST_DONE);
    assign gen_count_out = gen_q;
    assign state_out     = state_q;

endmodule

// File: tb/tb_life_stepper.sv
// Directed bench for life_stepper: board patterns with hand-computed next
// generations, cycle counts, ignored start, mid-run reset, longer read latency.
module tb_life_stepper;
    import life_stepper_pkg::*;

    localparam int RL_A = 2;
    localparam int RL_B = 3;
    localparam int GW   = 16;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start_a, start_b;

    word_t          rdata_a, rdata_b, wdata_a, wdata_b;
    addr_t          raddr_a, waddr_a, raddr_b, waddr_b;
    logic           we_a, busy_a, done_a, we_b, busy_b, done_b;
    logic [GW-1:0]  gen_a, gen_b;
    stepper_state_t st_a, st_b;

    life_stepper #(.READ_LATENCY(RL_A), .GEN_WIDTH(GW)) dut_a (
        .clk_130mhz(clk), .rst_in(rst), .start_in(start_a), .data_r_in(rdata_a),
        .addr_r_out(raddr_a), .addr_w_out(waddr_a), .data_w_out(wdata_a),
        .we_out(we_a), .busy_out(busy_a), .done_out(done_a),
        .gen_count_out(gen_a), .state_out(st_a)
    );

    life_stepper #(.READ_LATENCY(RL_B), .GEN_WIDTH(GW)) dut_b (
        .clk_130mhz(clk), .rst_in(rst), .start_in(start_b), .data_r_in(rdata_b),
        .addr_r_out(raddr_b), .addr_w_out(waddr_b), .data_w_out(wdata_b),
        .we_out(we_b), .busy_out(busy_b), .done_out(done_b),
        .gen_count_out(gen_b), .state_out(st_b)
    );

    // board buffers and read-latency models
    word_t src   [NUM_WORDS];
    word_t dst   [NUM_WORDS];
    word_t exp_b [NUM_WORDS];
    word_t pipe_a [RL_A];
    word_t pipe_b [RL_B];

    always @(posedge clk) begin
        pipe_a[0] <= src[raddr_a];
        pipe_a[1] <= pipe_a[0];
        pipe_b[0] <= src[raddr_b];
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign rdata_a = pipe_a[RL_A-1];
    assign rdata_b = pipe_b[RL_B-1];

    // monitor mux: which instance the running generation watches
    logic          mon_sel;
    logic          mon_we, mon_done, mon_busy;
    addr_t         mon_waddr;
    word_t         mon_wdata;
    logic [GW-1:0] mon_gen;
    assign mon_we    = mon_sel ? we_b    : we_a;
    assign mon_done  = mon_sel ? done_b  : done_a;
    assign mon_busy  = mon_sel ? busy_b  : busy_a;
    assign mon_waddr = mon_sel ? waddr_b : waddr_a;
    assign mon_wdata = mon_sel ? wdata_b : wdata_a;
    assign mon_gen   = mon_sel ? gen_b   : gen_a;

    // scoreboard
    int          total;
    int          bad;
    int          exp_gen [2];
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_src();
        foreach (src[i]) src[i] = '0;
    endtask

    task automatic clear_exp();
        foreach (exp_b[i]) exp_b[i] = '0;
    endtask

    task automatic set_src(input int x, input int y);
        int xx, yy;
        xx = x % BOARD_SIZE;
        yy = y % BOARD_SIZE;
        src[yy*WORDS_PER_ROW + xx/WORD_SIZE][WORD_SIZE-1-(xx%WORD_SIZE)] = 1'b1;
    endtask

    task automatic set_exp(input int x, input int y);
        int xx, yy;
        xx = x % BOARD_SIZE;
        yy = y % BOARD_SIZE;
        exp_b[yy*WORDS_PER_ROW + xx/WORD_SIZE][WORD_SIZE-1-(xx%WORD_SIZE)] = 1'b1;
    endtask

    task automatic compare_board(input string tag);
        foreach (src[i]) check($sformatf("%s_w%0d", tag, i), 32'(src[i]), 32'(exp_b[i]));
    endtask

    task automatic load_blinker();
        clear_src();
        set_src(5, 4); set_src(5, 5); set_src(5, 6);
        clear_exp();
        set_exp(4, 5); set_exp(5, 5); set_exp(6, 5);
    endtask

    task automatic drive_start(input logic sel, input logic v);
        if (sel) start_b = v;
        else     start_a = v;
    endtask

    // One generation on the selected instance; optionally pokes start while busy.
    task automatic run_gen(input logic sel, input int per_word, input int poke_at);
        int n, writes, dones, done_n, budget;
        logic finished;
        logic [31:0] e;
        mon_sel = sel;
        foreach (dst[i]) dst[i] = 16'hA5A5;
        exp_q.delete();
        for (int a = 0; a < NUM_WORDS; a++) exp_q.push_back(32'(a));
        writes = 0; dones = 0; done_n = 0; n = 0; finished = 1'b0;
        budget = NUM_WORDS*per_word + 40;
        @(negedge clk);
        drive_start(sel, 1'b1);
        while (!finished && n < budget) begin
            @(negedge clk);
            n++;
            drive_start(sel, n == poke_at);
            if (mon_we) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
                check("waddr", 32'(mon_waddr), e);
                dst[mon_waddr] = mon_wdata;
                writes++;
            end
            if (mon_done) begin
                dones++;
                if (dones == 1) begin
                    done_n = n;
                    check("done_cycle", 32'(n), 32'(NUM_WORDS*per_word + 1));
                    check("gen_count", 32'(mon_gen), 32'(exp_gen[sel] + 1));
                    check("busy_at_done", 32'(mon_busy), 32'd0);
                end
            end
            if (dones > 0 && n >= done_n + 20) finished = 1'b1;
        end
        drive_start(sel, 1'b0);
        check("gen_finished", 32'(finished), 32'd1);
        check("write_count", 32'(writes), 32'(NUM_WORDS));
        check("done_count", 32'(dones), 32'd1);
        exp_gen[sel] = exp_gen[sel] + 1;
        foreach (src[i]) src[i] = dst[i];
    endtask

    task automatic reset_mid_gen();
        int n, writes, extra;
        load_blinker();
        mon_sel = 1'b0;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        writes = 0; n = 0;
        while (writes < 50 && n < 2000) begin
            @(negedge clk);
            n++;
            if (we_a) writes++;
        end
        check("we_before_rst", 32'(writes), 32'd50);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        check("rst_we", 32'(we_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_waddr", 32'(waddr_a), 32'd0);
        check("rst_gen", 32'(gen_a), 32'd0);
        check("rst_state", 32'(st_a), 32'(ST_IDLE));
        rst = 1'b0;
        exp_gen[0] = 0;
        exp_gen[1] = 0;
        extra = 0;
        repeat (30) begin
            @(negedge clk);
            if (we_a) extra++;
        end
        check("we_after_rst", 32'(extra), 32'd0);
        run_gen(1'b0, 13, 0);
        compare_board("after_rst");
    endtask

    initial begin
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; mon_sel = 1'b0;
        total = 0; bad = 0; exp_gen[0] = 0; exp_gen[1] = 0;
        clear_src();
        clear_exp();
        repeat (3) @(negedge clk);
        check("reset_we", 32'(we_a), 32'd0);
        check("reset_busy", 32'(busy_a), 32'd0);
        check("reset_done", 32'(done_a), 32'd0);
        check("reset_gen", 32'(gen_a), 32'd0);
        check("reset_waddr", 32'(waddr_a), 32'd0);
        check("reset_wdata", 32'(wdata_a), 32'd0);
        check("reset_raddr", 32'(raddr_a), 32'd0);
        check("reset_state", 32'(st_a), 32'(ST_IDLE));
        @(negedge clk) rst = 1'b0;

        load_blinker();
        run_gen(1'b0, 13, 0);
        compare_board("blinker");

        clear_src();
        set_src(WORD_SIZE-1, 0); set_src(WORD_SIZE, 0); set_src(WORD_SIZE+1, 0);
        clear_exp();
        set_exp(WORD_SIZE, BOARD_SIZE-1); set_exp(WORD_SIZE, 0); set_exp(WORD_SIZE, 1);
        run_gen(1'b0, 13, 0);
        compare_board("torus_blinker");

        clear_src();
        set_src(0, 0); set_src(1, 0); set_src(0, 1); set_src(1, 1);
        set_src(20, 10);
        clear_exp();
        set_exp(0, 0); set_exp(1, 0); set_exp(0, 1); set_exp(1, 1);
        run_gen(1'b0, 13, 0);
        compare_board("block_lone");

        // glider .X. / ..X / XXX with its box at (30,30), then at (31,31)
        clear_src();
        set_src(31, 30); set_src(32, 31); set_src(30, 32); set_src(31, 32); set_src(32, 32);
        clear_exp();
        set_exp(32, 31); set_exp(33, 32); set_exp(31, 33); set_exp(32, 33); set_exp(33, 33);
        repeat (4) run_gen(1'b0, 13, 0);
        compare_board("glider");

        load_blinker();
        run_gen(1'b0, 13, 100);
        compare_board("start_ignored");

        reset_mid_gen();

        load_blinker();
        run_gen(1'b1, 14, 0);
        compare_board("blinker_rl3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
